// File: rtl/strided_pool_layer.sv
// strided_pool_layer: streaming KxK max/average pooling with a configurable stride.
// All CHANNELS lanes run in lockstep from one raster-order pixel stream.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   i_start, i_mode   frame start pulse; 0 = max, 1 = avg (captured with i_start)
//   i_valid, i_data   input pixel handshake, CHANNELS x DATA_SIZE packed (ch0 in LSBs)
//   o_ready           pixel accepted this cycle when i_valid is high
//   i_next_ready      downstream accepts o_data this cycle
//   o_valid, o_data   pooled pixel, CHANNELS x DATA_SIZE packed
//   o_done            one-cycle end-of-frame pulse

// Per-channel line buffer, window reduction and output register.
module strided_pool_lane #(
  parameter int DATA_SIZE  = 8,
  parameter int IMG_DIM    = 13,
  parameter int KERNEL_DIM = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_i,
  input  logic                 load_i,
  input  logic                 mode_i,
  input  logic [DATA_SIZE-1:0] pix_i,
  output logic [DATA_SIZE-1:0] res_o
);
  localparam int FIFO_LENGTH = IMG_DIM*(KERNEL_DIM-1) + KERNEL_DIM;
  localparam int KK          = KERNEL_DIM*KERNEL_DIM;
  localparam int SUM_W       = DATA_SIZE + $clog2(KK);
  // Slot 0 of the FIFO is the incoming pixel itself, so only the older
  // FIFO_LENGTH-1 slots need flops.
  localparam int DEPTH       = (FIFO_LENGTH > 1) ? FIFO_LENGTH-1 : 1;

  logic [DATA_SIZE-1:0] fifo_q [DEPTH];
  logic [DATA_SIZE-1:0] nxt    [FIFO_LENGTH];
  logic [DATA_SIZE-1:0] max_c;
  logic [SUM_W-1:0]     sum_c;
  logic [DATA_SIZE-1:0] res_q, res_d;

  // FIFO contents as they will be after this cycle's shift; the window is
  // evaluated on this view so it includes the pixel being accepted.
  always_comb begin
    nxt[0] = pix_i;
    for (int k = 1; k < FIFO_LENGTH; k++) nxt[k] = fifo_q[k-1];
  end

  always_comb begin
    max_c = '0;
    sum_c = '0;
    for (int r = 0; r < KERNEL_DIM; r++) begin
      for (int c = 0; c < KERNEL_DIM; c++) begin
        if (nxt[r*IMG_DIM+c] > max_c) max_c = nxt[r*IMG_DIM+c];
        sum_c = sum_c + SUM_W'(nxt[r*IMG_DIM+c]);
      end
    end
    res_d = mode_i ? DATA_SIZE'(sum_c / SUM_W'(KK)) : max_c;
  end

  // Line buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (shift_i) begin
      for (int k = 0; k < DEPTH; k++) fifo_q[k] <= nxt[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         res_q <= '0;
    else if (load_i) res_q <= res_d;
  end

  assign res_o = res_q;
endmodule

module strided_pool_layer #(
  parameter int DATA_SIZE  = 8,
  parameter int CHANNELS   = 16,
  parameter int IMG_DIM    = 13,
  parameter int KERNEL_DIM = 3,
  parameter int STRIDE     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic                          i_mode,
  input  logic                          i_valid,
  input  logic [CHANNELS*DATA_SIZE-1:0] i_data,
  output logic                          o_ready,
  input  logic                          i_next_ready,
  output logic                          o_valid,
  output logic [CHANNELS*DATA_SIZE-1:0] o_data,
  output logic                          o_done
);
  localparam int RC_W  = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam int NPIX  = IMG_DIM*IMG_DIM;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              vld_q, vld_d;
  logic              accept, hit, load;

  assign o_ready = (state_q == S_RUN) && (!vld_q || i_next_ready);
  assign accept  = i_valid && o_ready;
  assign o_valid = vld_q;
  assign o_done  = (state_q == S_DONE);

  // Window hit: bottom-right corner of a window lands on the stride grid.
  // Grid positions beyond OUT_DIM cannot arise since the corner stays inside the image.
  always_comb begin
    hit = (int'(row_q) >= KERNEL_DIM-1) && (int'(col_q) >= KERNEL_DIM-1) &&
          ((int'(row_q) - (KERNEL_DIM-1)) % STRIDE == 0) &&
          ((int'(col_q) - (KERNEL_DIM-1)) % STRIDE == 0);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    vld_d   = vld_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_RUN;
        row_d   = '0;
        col_d   = '0;
        cnt_d   = '0;
        mode_d  = i_mode;
      end
      S_RUN: if (accept) begin
        if (cnt_q == CNT_W'(NPIX-1)) begin
          state_d = S_DRAIN;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (col_q == RC_W'(IMG_DIM-1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: if (!vld_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // o_ready guarantees a hit only lands when the held result is free or leaving.
    if (accept && hit) begin
      vld_d = 1'b1;
      load  = 1'b1;
    end else if (vld_q && i_next_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      vld_q   <= vld_d;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    strided_pool_lane #(
      .DATA_SIZE (DATA_SIZE),
      .IMG_DIM   (IMG_DIM),
      .KERNEL_DIM(KERNEL_DIM)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .shift_i(accept),
      .load_i (load),
      .mode_i (mode_q),
      .pix_i  (i_data[ch*DATA_SIZE +: DATA_SIZE]),
      .res_o  (o_data[ch*DATA_SIZE +: DATA_SIZE])
    );
  end
endmodule
